// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the multi-cycle data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // Big-endian byte enables; bit 3 selects bits [31:24].
  function automatic logic [3:0] lane_be(size_t sz, logic [1:0] off);
    case (sz)
      SZ_B:    lane_be = 4'b1000 >> off;
      SZ_H:    lane_be = off[1] ? 4'b0011 : 4'b1100;
      SZ_W:    lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  endfunction

  // Replicates right-justified store data into every lane so the byte
  // enables alone decide what lands in memory.
  function automatic logic [31:0] lane_data(size_t sz, logic [31:0] wd);
    case (sz)
      SZ_B:    lane_data = {4{wd[7:0]}};
      SZ_H:    lane_data = {2{wd[15:0]}};
      default: lane_data = wd;
    endcase
  endfunction

  // Pulls the addressed lane(s) down to bit 0 and extends them.
  function automatic logic [31:0] load_extend(logic [31:0] word, size_t sz,
                                              logic [1:0] off, logic uns);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    sh_b = word >> {~off, 3'b000};
    sh_h = off[1] ? word : (word >> 16);
    case (sz)
      SZ_B:    load_extend = uns ? {24'b0, sh_b[7:0]}  : {{24{sh_b[7]}}, sh_b[7:0]};
      SZ_H:    load_extend = uns ? {16'b0, sh_h[15:0]} : {{16{sh_h[15]}}, sh_h[15:0]};
      SZ_W:    load_extend = word;
      default: load_extend = '0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: combinational read, byte-enabled synchronous write.
module dmem_array #(
  parameter int DEPTH = 64
) (
  input  logic                                  clk,
  input  logic                                  we_i,
  input  logic [3:0]                            be_i,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] addr_i,
  input  logic [31:0]                           wdata_i,
  output logic [31:0]                           rdata_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [31:0] mem_q [DEPTH];

  // Byte-lane write of the addressed word.
  // NOTE: storage carries no reset; contents survive reset and are written
  // only through the byte enables. Sequential state uses <= so every
  // register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = ({1'b0, addr_i} < DEPTH_L) ? mem_q[addr_i] : '0;

endmodule

// File: rtl/dmem_mc.sv
// Multi-cycle data memory: req/ready/valid handshake, programmable latency,
// byte/half/word big-endian access with extension and fault reporting.
module dmem_mc
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic        ready,
  output logic        valid,
  output logic [31:0] rd,
  output logic        fault
);

  localparam int CW = $clog2(LAT) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          fault_q, fault_d;
  logic [31:0]   rd_q, rd_d;

  logic          we_q;
  size_t         size_q;
  logic          uns_q;
  logic [31:0]   a_q;
  logic [31:0]   wd_q;

  logic          accept;
  logic          commit;
  logic          idx_oor;
  logic          req_fault;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  // Fault check runs on the latched request, never on live inputs.
  assign idx_oor   = {2'b00, a_q[31:2]} >= 32'(DEPTH);
  assign req_fault = (size_q == SZ_RSV)
                   || (size_q == SZ_H && a_q[0])
                   || (size_q == SZ_W && a_q[1:0] != 2'b00)
                   || idx_oor;

  // Reset on the commit edge must suppress the write.
  assign mem_we = commit && we_q && !req_fault && !reset;
  assign ready  = (state_q == IDLE) && !reset;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .be_i    (lane_be(size_q, a_q[1:0])),
    .addr_i  (a_q[AW+1:2]),
    .wdata_i (lane_data(size_q, wd_q)),
    .rdata_o (mem_rdata)
  );

  // Next-state, wait counter and completion outputs.
  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    valid_d = 1'b0;
    fault_d = 1'b0;
    rd_d    = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = BUSY;
          cnt_d   = CW'(LAT - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = DONE;
          valid_d = 1'b1;
          fault_d = req_fault;
          rd_d    = (req_fault || we_q) ? '0
                  : load_extend(mem_rdata, size_q, a_q[1:0], uns_q);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state and registered completion outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      rd_q    <= rd_d;
    end
  end

  // Request latch, loaded only at the accept edge; a reset in the same
  // cycle leaves the FSM idle so the stale latch is never used.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q   <= we;
      size_q <= size_t'(size);
      uns_q  <= uns;
      a_q    <= a;
      wd_q   <= wd;
    end
  end

  assign valid = valid_q;
  assign fault = fault_q;
  assign rd    = rd_q;

endmodule

// File: doc/dmem_mc.md
# dmem_mc

Multi-cycle, parametrised data memory for the single-cycle/multi-cycle MIPS datapath. It replaces the always-ready word/byte store with a req/ready/valid handshake and a programmable access latency. It supports byte, halfword and word loads and stores, with sign or zero extension on loads, big-endian lane mapping, and fault reporting for misaligned or out-of-range accesses. It sits between the datapath's memory stage and the controller, which stalls on `ready`/`valid`.

## Interface
- `DEPTH`, 64: number of 32-bit words; any value ≥ 1.
- `LAT`, 2: access wait cycles after acceptance; ≥ 1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: request strobe.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `uns` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `a` in 32: byte address.
- `wd` in 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `ready` out 1: block idle and will accept `req` this cycle.
- `valid` out 1: one-cycle completion pulse.
- `rd` out 32: extended load data; valid only while `valid`=1.
- `fault` out 1: qualifies `valid`; request was rejected.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: `ready`=1. On `req`=1, latch `we`, `size`, `uns`, `a`, `wd` and enter BUSY with the wait counter = LAT-1.
- BUSY: `ready`=0. Decrement the counter. At counter 0, the next edge performs the access and enters DONE.
- DONE: `valid`=1 for exactly one cycle, then return to IDLE.
- Fault conditions, evaluated on the latched request:
  - `size`=11.
  - Half with a[0]≠0.
  - Word with a[1:0]≠0.
  - Word index a[31:2] ≥ DEPTH.
- Faulted request:
  - Takes the full latency.
  - Memory is unchanged.
  - `rd`=0 and `fault`=1 in DONE.
- Byte-lane mapping (big-endian):
  - Byte offset 0 → [31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0].
  - Half offset 0 → [31:16], 2 → [15:0].
- Store: writes only the addressed lanes, using byte enables. Other lanes are untouched.
- Load: extracts the addressed lane(s), right-justifies them, then zero- or sign-extends per `uns`. Word loads ignore `uns`.
- Stores complete with `rd`=0.
- `req` while `ready`=0 is ignored. There is no queueing; the requester re-issues after `valid`.
- Inputs are sampled only at the accept edge. Later changes during BUSY have no effect.

## Timing
- Accept edge E0 (IDLE, `req`=1).
- BUSY occupies cycles E0..E0+LAT-1.
- Memory write and read capture happen at edge E0+LAT.
- `valid`, `rd` and `fault` are registered and high during the cycle after E0+LAT.
- Back in IDLE (`ready`=1) after edge E0+LAT+1.
- Throughput: one access per LAT+2 cycles. Back-to-back: `req` held high re-issues in the first IDLE cycle.
- Reset: at any edge with `reset`=1, go to IDLE with `valid`=0, `fault`=0, `rd`=0. `ready` is forced 0 while `reset`=1.
- Reset during BUSY aborts the request. An uncommitted store is discarded.
- Memory contents are not reset.
- Reset coinciding with the commit edge: reset wins and no write occurs.

## Structure
- Package `dmem_pkg`:
  - `size_t` enum: SZ_B, SZ_H, SZ_W, SZ_RSV.
  - `state_t` enum: IDLE, BUSY, DONE.
  - Lane-mapping function returning 4-bit byte enables.
  - Extension function for load alignment.
- Sub-module `dmem_array`: DEPTH×32 storage with combinational read, a synchronous write, and a 4-bit byte-enable input (bit 3 = [31:24]).
- `dmem_mc` holds the FSM, counter, request latch, fault check, lane logic and output registers.
- Wait-counter width: $clog2(LAT)+1.

## Test plan
- Word store then load, LAT=2: store 0xDEADBEEF @0x10; load @0x10.
  - Each `valid` occurs 3 cycles after the accept edge.
  - Load `rd`=0xDEADBEEF, `fault`=0.
- Byte lanes: after the word above, store byte 0x55 @0x11, then load word @0x10.
  - Load returns 0xDE55BEEF.
  - lb @0x10 → 0xFFFFFFDE; lbu @0x10 → 0x000000DE.
- Halfwords: lh @0x12 → 0xFFFFBEEF; lhu → 0x0000BEEF.
  - Store half 0x1234 @0x10, then load word → 0x1234BEEF.
- Faults, each with `valid` after full latency and memory unchanged:
  - lh @0x11 → `fault`=1, `rd`=0.
  - sw @0x12 → `fault`=1.
  - sw @4·DEPTH → `fault`=1.
  - `size`=11 → `fault`=1.
- Handshake: pulse `req` during BUSY with a different store → ignored. Subsequent load shows the original data and only one `valid` pulse.
- Reset mid-op: assert `reset` in the last BUSY cycle of a store 0xCAFEF00D @0x20.
  - No `valid`.
  - Load @0x20 returns the prior contents.
  - `ready`=1 the cycle after `reset` drops.
